// File: rtl/if_id_queue_if.sv
// IF/ID queue handshake bundle: IF push side, ID output side, and EX/global controls.
// The master drives the queue inputs; the slave is the queue itself.
interface if_id_queue_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter int DEPTH      = 4,
   localparam int PTR_W     = $clog2(DEPTH)
);
   logic                  rdy;
   logic                  if_flag;
   logic [ADDR_WIDTH-1:0] if_pc;
   logic [INST_WIDTH-1:0] if_inst;
   logic                  if_ready;
   logic                  id_stall;
   logic                  flush;
   logic                  id_flag;
   logic [ADDR_WIDTH-1:0] id_pc;
   logic [INST_WIDTH-1:0] id_inst;
   logic [PTR_W:0]        count;

   modport master (
      output rdy, if_flag, if_pc, if_inst, id_stall, flush,
      input  if_ready, id_flag, id_pc, id_inst, count
   );

   modport slave (
      input  rdy, if_flag, if_pc, if_inst, id_stall, flush,
      output if_ready, id_flag, id_pc, id_inst, count
   );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry FIFO feeding a registered output stage to ID.
// An empty FIFO lets a fresh instruction bypass straight into the output stage.
module if_id_queue #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter int DEPTH      = 4,
   localparam int PTR_W     = $clog2(DEPTH)
) (
   input logic         clk,
   input logic         rst,
   if_id_queue_if.slave bus
);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [INST_WIDTH-1:0] inst;
   } entry_t;

   entry_t                mem_q [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]        count_q, count_d;
   logic                  id_flag_q, id_flag_d;
   logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
   logic [INST_WIDTH-1:0] id_inst_q, id_inst_d;

   logic ready, empty, push, advance, bypass, wr_en, pop;

   assign ready   = count_q < DEPTH_C;
   assign empty   = (count_q == '0);
   assign push    = bus.if_flag & ready & bus.rdy & ~bus.flush;
   assign advance = bus.rdy & ~bus.flush & ~bus.id_stall;
   assign bypass  = advance & empty & push;
   assign wr_en   = push & ~bypass;
   assign pop     = advance & ~empty;

   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      id_flag_d = id_flag_q;
      id_pc_d   = id_pc_q;
      id_inst_d = id_inst_q;

      if (bus.rdy && bus.flush) begin
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         count_d   = '0;
         id_flag_d = 1'b0;
         id_pc_d   = '0;
         id_inst_d = '0;
      end else begin
         if (pop) begin
            id_flag_d = 1'b1;
            id_pc_d   = mem_q[rd_ptr_q].pc;
            id_inst_d = mem_q[rd_ptr_q].inst;
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
         end else if (bypass) begin
            id_flag_d = 1'b1;
            id_pc_d   = bus.if_pc;
            id_inst_d = bus.if_inst;
         end else if (advance) begin
            id_flag_d = 1'b0;
            id_pc_d   = '0;
            id_inst_d = '0;
         end

         if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);

         // Simultaneous write and pop leave occupancy unchanged.
         case ({wr_en, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         id_flag_q <= 1'b0;
         id_pc_q   <= '0;
         id_inst_q <= '0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         id_flag_q <= id_flag_d;
         id_pc_q   <= id_pc_d;
         id_inst_q <= id_inst_d;
      end
   end

   // Storage carries no reset; occupancy alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= '{pc: bus.if_pc, inst: bus.if_inst};
   end

   assign bus.if_ready = ready;
   assign bus.id_flag  = id_flag_q;
   assign bus.id_pc    = id_pc_q;
   assign bus.id_inst  = id_inst_q;
   assign bus.count    = count_q;
endmodule
